rf_onehot_wr: RTL and testbench
===============================

Name: rf_onehot_wr

Overview:
- 32-entry RV32I integer register file for the single-cycle core.
- Sits directly downstream of the one-hot decoder. The decoder turns rd into a one-hot write-select vector, and this block consumes that vector as its per-register write enable.
- Two asynchronous read ports (rs1, rs2) feed the ALU and branch stage. One synchronous write port is written from writeback.
- Monitors the one-hot vector and flags malformed selects.

Parameters:
- DEPTH, 32, number of registers; must be a power of two, >= 2; equals the decoder's DEPTH.
- WIDTH, 32, data width in bits.
- ADDR_W, $clog2(DEPTH), read-address width; derived, never overridden.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- wr_en  in  1  writeback valid (RegWrite).
- wr_sel_oh  in  DEPTH  one-hot write select from the decoder; bit i selects register i.
- wr_data  in  WIDTH  writeback data.
- rd_addr_a  in  ADDR_W  rs1 index.
- rd_addr_b  in  ADDR_W  rs2 index.
- rd_data_a  out  WIDTH  rs1 value, combinational.
- rd_data_b  out  WIDTH  rs2 value, combinational.
- oh_err  out  1  sticky malformed-select flag.
- wr_count  out  16  count of committed writes; saturates.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - all registers, oh_err and wr_count go to 0.
  - Reset has priority over a simultaneous write; no write commits in that cycle.
- Legal write: wr_en=1 and popcount(wr_sel_oh)==1.
  - Register i (bit i set) takes wr_data at the rising edge.
  - Latency 1 cycle: the new value is visible on the read ports after that edge.
- Register 0 is hardwired zero.
  - A legal write selecting bit 0 is discarded silently and counted as ignored, not as an error.
  - Reads of address 0 always return 0.
- Illegal select: wr_en=1 and popcount(wr_sel_oh)!=1, i.e. zero bits or more than one bit set.
  - No register changes.
  - oh_err goes to 1 at that edge and stays 1 until reset.
- wr_en=0: wr_sel_oh is ignored entirely, including its validity; no error is raised.
- Reads: rd_data_x = reg[rd_addr_x], purely combinational from the current register state. No same-cycle forwarding unless the optional feature below is compiled in.
- wr_count:
  - increments by 1 on each committed write to a register other than 0.
  - saturates at 16'hFFFF with no wrap-around.
  - Illegal and bit-0 writes do not count.
- Both read ports may address the same register, and either may match the write target, in any cycle. All combinations are legal.
- Outputs never go X after reset, regardless of X on wr_sel_oh while wr_en=0.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: when a legal write to register i≠0 is present this cycle and rd_addr_x==i, rd_data_x returns wr_data combinationally in the same cycle (write-through).
- Not defined: rd_data_x returns the old stored value until the edge.
- Register-0 and illegal-select behaviour are identical in both builds.

Decomposition:
- Package rf_pkg holds:
  - localparams RF_DEPTH=32, RF_WIDTH=32, RF_ADDR_W=5, RF_CNT_W=16;
  - typedefs word_t (logic [RF_WIDTH-1:0]), reg_idx_t (logic [RF_ADDR_W-1:0]) and onehot_t (logic [RF_DEPTH-1:0]).
- Natural sub-module: rf_onehot_check.
  - Input: the one-hot vector.
  - Outputs: is_onehot (exactly one bit set) and is_zero_sel (bit 0 set).
  - Combinational; instantiated once.

Test Plan:
- Reset then reads: rst_n=0 for 2 cycles, then read addrs 0..31 -> all rd_data=0, oh_err=0, wr_count=0.
- Legal write: wr_en=1, wr_sel_oh=32'h0000_0020, wr_data=32'hDEADBEEF; next cycle rd_addr_a=5 -> 32'hDEADBEEF, wr_count=1. Without the macro, same-cycle read of 5 -> 0; with RF_WRITE_BYPASS_EN -> 32'hDEADBEEF.
- x0 protection: wr_en=1, wr_sel_oh=32'h1, wr_data=32'hFFFF_FFFF -> rd_addr_b=0 reads 0, wr_count unchanged, oh_err=0.
- Illegal selects: wr_en=1 with wr_sel_oh=32'h0000_0006, then with 32'h0 -> registers 1, 2 unchanged, oh_err=1 after the first edge and still 1 ten cycles later. The same patterns with wr_en=0 -> oh_err stays 0.
- Reset mid-write: rst_n=0 in the same cycle as wr_en=1, wr_sel_oh=32'h0000_0100, wr_data=32'h1234 -> reg 8 reads 0 afterwards, wr_count=0, oh_err cleared.
- Saturation and decoder chain: drive the decoder with index cycling 1..31 into wr_sel_oh for 70000 writes -> every register holds its last data, wr_count=16'hFFFF, and it stays there on further writes.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared sizing constants and types for the one-hot-written register file.
//   RF_DEPTH  - number of architectural registers
//   RF_WIDTH  - register data width
//   RF_ADDR_W - read-address width
//   RF_CNT_W  - width of the committed-write counter
package rf_pkg;

  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_WIDTH  = 32;
  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_CNT_W  = 16;

  typedef logic [RF_WIDTH-1:0]  word_t;
  typedef logic [RF_ADDR_W-1:0] reg_idx_t;
  typedef logic [RF_DEPTH-1:0]  onehot_t;

endpackage

// File: rtl/rf_onehot_check.sv
// Combinational validity check of a write-select vector.
// Ports:
//   oh_i          - select vector from the decoder
//   is_onehot_o   - exactly one bit of oh_i is set
//   is_zero_sel_o - bit 0 (the hardwired-zero register) is set
module rf_onehot_check #(
  parameter int unsigned DEPTH = 32
) (
  input  logic [DEPTH-1:0] oh_i,
  output logic             is_onehot_o,
  output logic             is_zero_sel_o
);

  // Clearing the lowest set bit leaves zero only for a power of two.
  always_comb begin
    is_onehot_o   = (oh_i != '0) && ((oh_i & (oh_i - DEPTH'(1))) == '0);
    is_zero_sel_o = oh_i[0];
  end

endmodule

// File: rtl/rf_onehot_wr.sv
// 32-entry RV32I register file with a one-hot write select.
// Two combinational read ports, one synchronous write port, a sticky flag for
// malformed selects and a saturating count of committed writes.
// Optional build macro: RF_WRITE_BYPASS_EN makes a legal write to a non-zero
// register visible on a matching read port in the same cycle.
// Ports:
//   clk        - core clock, all state updates on the rising edge
//   rst_n      - synchronous active-low reset
//   wr_en      - writeback valid
//   wr_sel_oh  - one-hot write select, bit i selects register i
//   wr_data    - writeback data
//   rd_addr_a  - rs1 index          rd_data_a - rs1 value
//   rd_addr_b  - rs2 index          rd_data_b - rs2 value
//   oh_err     - sticky malformed-select flag, cleared only by reset
//   wr_count   - saturating count of committed writes to registers 1..DEPTH-1
module rf_onehot_wr
  import rf_pkg::*;
#(
  parameter  int unsigned DEPTH  = RF_DEPTH,
  parameter  int unsigned WIDTH  = RF_WIDTH,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [DEPTH-1:0]    wr_sel_oh,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [ADDR_W-1:0]   rd_addr_a,
  input  logic [ADDR_W-1:0]   rd_addr_b,
  output logic [WIDTH-1:0]    rd_data_a,
  output logic [WIDTH-1:0]    rd_data_b,
  output logic                oh_err,
  output logic [RF_CNT_W-1:0] wr_count
);

  logic             is_onehot;
  logic             is_zero_sel;
  logic             commit;
  logic             illegal;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic             oh_err_q, oh_err_d;
  logic [RF_CNT_W-1:0] cnt_q, cnt_d;

  rf_onehot_check #(
    .DEPTH(DEPTH)
  ) u_check (
    .oh_i         (wr_sel_oh),
    .is_onehot_o  (is_onehot),
    .is_zero_sel_o(is_zero_sel)
  );

  // wr_en gates everything so a floating select while idle cannot leak in.
  always_comb begin
    commit   = wr_en && is_onehot && !is_zero_sel;
    illegal  = wr_en && !is_onehot;
    oh_err_d = oh_err_q | illegal;
    cnt_d    = cnt_q;
    if (commit && (cnt_q != '1)) begin
      cnt_d = cnt_q + RF_CNT_W'(1);
    end
  end

  // Entry 0 is never written (commit excludes bit 0), so it stays at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      oh_err_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (commit && wr_sel_oh[i]) begin
          regs_q[i] <= wr_data;
        end
      end
      oh_err_q <= oh_err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    rd_data_b = regs_q[rd_addr_b];
`ifdef RF_WRITE_BYPASS_EN
    if (commit && wr_sel_oh[rd_addr_a]) begin
      rd_data_a = wr_data;
    end
    if (commit && wr_sel_oh[rd_addr_b]) begin
      rd_data_b = wr_data;
    end
`endif
    if (rd_addr_a == '0) begin
      rd_data_a = '0;
    end
    if (rd_addr_b == '0) begin
      rd_data_b = '0;
    end
  end

  assign oh_err   = oh_err_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_rf_onehot_wr.sv
module tb_rf_onehot_wr;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_sel_oh;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic        oh_err;
  logic [15:0] wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural contents, sticky error, write count.
  logic [31:0] m_reg [32];
  logic        m_err;
  int unsigned m_cnt;

  rf_onehot_wr dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_sel_oh(wr_sel_oh),
    .wr_data  (wr_data),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .oh_err   (oh_err),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and apply the spec rules to the model with the inputs held.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
      m_err = 1'b0;
      m_cnt = 0;
    end else if (wr_en) begin
      if ($countones(wr_sel_oh) != 1) begin
        m_err = 1'b1;
      end else begin
        for (int i = 1; i < 32; i++) begin
          if (wr_sel_oh[i]) begin
            m_reg[i] = wr_data;
            if (m_cnt < 65535) m_cnt++;
          end
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic en, input logic [31:0] sel, input logic [31:0] data);
    wr_en     = en;
    wr_sel_oh = sel;
    wr_data   = data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    tick();
    rst_n = 1'b1;
  endtask

  // Value a read port should show right now, before the next edge.
  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && ($countones(wr_sel_oh) == 1) && wr_sel_oh[a]) return wr_data;
`endif
    return m_reg[a];
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0040, 32'hA5A5_A5A5);
    tick();
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      n_checks++;
      if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read addr=%0d got a=%h b=%h want 0", i, rd_data_a, rd_data_b);
      end
    end
    n_checks++;
    if (oh_err !== 1'b0 || wr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_state got err=%b cnt=%h want err=0 cnt=0", oh_err, wr_count);
    end
  endtask

  task automatic test_legal_write();
    logic [31:0] same_cycle_exp;
`ifdef RF_WRITE_BYPASS_EN
    same_cycle_exp = 32'hDEAD_BEEF;
`else
    same_cycle_exp = 32'h0;
`endif
    drive(1'b1, 32'h0000_0020, 32'hDEAD_BEEF);
    rd_addr_a = 5'd5;
    #1;
    n_checks++;
    if (rd_data_a !== same_cycle_exp) begin
      n_fail++;
      $display("FAIL legal_same_cycle got %h want %h", rd_data_a, same_cycle_exp);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if (rd_data_a !== 32'hDEAD_BEEF || wr_count !== 16'd1) begin
      n_fail++;
      $display("FAIL legal_write got data=%h cnt=%h want DEADBEEF cnt=1", rd_data_a, wr_count);
    end
  endtask

  task automatic test_x0();
    drive(1'b1, 32'h0000_0001, 32'hFFFF_FFFF);
    rd_addr_b = 5'd0;
    #1;
    n_checks++;
    if (rd_data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL x0_same_cycle got %h want 0", rd_data_b);
    end
    tick();
    drive(1'b0, 32'h0, 32'h0);
    #1;
    n_checks++;
    if (rd_data_b !== 32'h0 || wr_count !== 16'd1 || oh_err !== 1'b0) begin
      n_fail++;
      $display("FAIL x0_write got data=%h cnt=%h err=%b want 0 1 0", rd_data_b, wr_count, oh_err);
    end
  endtask

  task automatic test_illegal();
    drive(1'b1, 32'h0000_0002, 32'h1111_1111);
    tick();
    drive(1'b1, 32'h0000_0004, 32'h2222_2222);
    tick();
    drive(1'b1, 32'h0000_0006, 32'h0BAD_0BAD);
    tick();
    n_checks++;
    if (oh_err !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_first_edge got err=%b want 1", oh_err);
    end
    drive(1'b1, 32'h0, 32'h0BAD_0BAD);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    rd_addr_a = 5'd1;
    rd_addr_b = 5'd2;
    #1;
    n_checks++;
    if (oh_err !== 1'b1 || wr_count !== 16'd3) begin
      n_fail++;
      $display("FAIL illegal_sticky got err=%b cnt=%h want 1 3", oh_err, wr_count);
    end
    n_checks++;
    if (rd_data_a !== 32'h1111_1111 || rd_data_b !== 32'h2222_2222) begin
      n_fail++;
      $display("FAIL illegal_regs got r1=%h r2=%h want 11111111 22222222", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_wr_en_low();
    do_reset();
    drive(1'b0, 32'h0000_0006, 32'hCAFE_0001);
    tick();
    drive(1'b0, 32'h0, 32'hCAFE_0002);
    tick();
    drive(1'b0, 32'hxxxx_xxxx, 32'hCAFE_0003);
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd0;
    #1;
    n_checks++;
    if (rd_data_a !== 32'h0 || rd_data_b !== 32'h0) begin
      n_fail++;
      $display("FAIL en_low_x_read got a=%h b=%h want 0 0", rd_data_a, rd_data_b);
    end
    tick();
    n_checks++;
    if (oh_err !== 1'b0 || wr_count !== 16'h0) begin
      n_fail++;
      $display("FAIL en_low_state got err=%b cnt=%h want 0 0", oh_err, wr_count);
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset_mid_write();
    drive(1'b1, 32'h0000_0100, 32'h0000_0055);
    tick();
    drive(1'b1, 32'h0000_0003, 32'h0);
    tick();
    rst_n = 1'b0;
    drive(1'b1, 32'h0000_0100, 32'h0000_1234);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    rd_addr_a = 5'd8;
    #1;
    n_checks++;
    if (rd_data_a !== 32'h0 || wr_count !== 16'h0 || oh_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_write got r8=%h cnt=%h err=%b want 0 0 0",
               rd_data_a, wr_count, oh_err);
    end
  endtask

  task automatic test_random();
    logic [31:0] sel;
    logic [31:0] ea, eb;
    int a, b, kind;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 39);
      a = $urandom_range(0, 31);
      if (kind == 0) sel = 32'h0;
      else if (kind == 1) begin
        b = (a + 1 + $urandom_range(0, 30)) % 32;
        sel = (32'h1 << a) | (32'h1 << b);
      end else sel = 32'h1 << a;
      drive($urandom_range(0, 3) != 0, sel, $urandom);
      rd_addr_a = 5'($urandom_range(0, 31));
      rd_addr_b = (n % 4 == 0) ? rd_addr_a : 5'($urandom_range(0, 31));
      #1;
      ea = exp_read(rd_addr_a);
      eb = exp_read(rd_addr_b);
      n_checks++;
      if (rd_data_a !== ea || rd_data_b !== eb) begin
        n_fail++;
        $display("FAIL random_read n=%0d a=%0d got %h want %h b=%0d got %h want %h",
                 n, rd_addr_a, rd_data_a, ea, rd_addr_b, rd_data_b, eb);
      end
      n_checks++;
      if (oh_err !== m_err || wr_count !== 16'(m_cnt)) begin
        n_fail++;
        $display("FAIL random_state n=%0d got err=%b cnt=%h want err=%b cnt=%h",
                 n, oh_err, wr_count, m_err, 16'(m_cnt));
      end
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 70000; n++) begin
      drive(1'b1, 32'h1 << (n % 31 + 1), $urandom);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      #1;
      n_checks++;
      if (rd_data_a !== m_reg[i]) begin
        n_fail++;
        $display("FAIL sat_regs reg=%0d got %h want %h", i, rd_data_a, m_reg[i]);
      end
    end
    n_checks++;
    if (wr_count !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_count got %h want FFFF", wr_count);
    end
    for (int n = 0; n < 5; n++) begin
      drive(1'b1, 32'h1 << (n + 3), 32'h7000_0000 + 32'(n));
      tick();
    end
    drive(1'b0, 32'h0, 32'h0);
    rd_addr_a = 5'd7;
    #1;
    n_checks++;
    if (wr_count !== 16'hFFFF || rd_data_a !== 32'h7000_0004) begin
      n_fail++;
      $display("FAIL sat_hold got cnt=%h r7=%h want FFFF 70000004", wr_count, rd_data_a);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    wr_en     = 1'b0;
    wr_sel_oh = 32'h0;
    wr_data   = 32'h0;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
    m_err = 1'b0;
    m_cnt = 0;
    #1;
    test_reset();
    test_legal_write();
    test_x0();
    test_illegal();
    test_wr_en_low();
    test_reset_mid_write();
    test_random();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
